truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1 (range 1..15): cycles each input vector is held before `s` is sampled.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a full 16-vector scan; honoured only in IDLE.
REQ-005 SHALL have port expected, input, 16 bits: golden truth table, bit i = required `s` for vector i.
REQ-006 SHALL have ports a, b, c, d, output, 1 bit each: vector driven to the function under test; {a,b,c,d} = vector index, a is MSB.
REQ-007 SHALL have port s, input, 1 bit: function response.
REQ-008 SHALL have port busy, output, 1 bit: high in DRIVE and SAMPLE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-010 SHALL have port table_out, output, 16 bits: captured truth table.
REQ-011 SHALL have port match, output, 1 bit: table_out == latched expected; valid from done until the next start.
REQ-012 SHALL have port mismatch_count, output, 5 bits: number of differing bits, 0..16.
REQ-013 SHALL have port first_fail, output, 4 bits: lowest mismatching index; 0 when match=1.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SAMPLE, DONE.
REQ-015 Transitions:
- IDLE with start=1 -> DRIVE.
- DRIVE after SETTLE_CYCLES cycles -> SAMPLE.
- SAMPLE -> DRIVE (index+1) or, at index 15, -> DONE.
- DONE -> IDLE after 1 cycle.
REQ-016 On accepting start, SHALL:
- latch `expected`;
- clear table_out, mismatch_count, first_fail and match;
- set index=0 and the settle counter to 0.
REQ-017 SHALL drive {a,b,c,d}=index throughout DRIVE and SAMPLE, and 4'b0000 in IDLE and DONE.
REQ-018 SHALL capture `s` into table_out[index] on the rising edge that ends SAMPLE.
REQ-019 On that same edge, when s != latched expected[index], SHALL:
- increment mismatch_count;
- load first_fail=index if it is the first mismatch of the scan.
REQ-020 SHALL assert done exactly 16*(SETTLE_CYCLES+1) rising edges after the edge that accepted start.
REQ-021 SHALL assert match together with done.
REQ-022 SHALL ignore start while busy=1 or in DONE; no restart and no result corruption.
REQ-023 SHALL hold results stable in IDLE until the next accepted start.
REQ-024 SHALL ignore changes on `expected` after start is accepted.
REQ-025 SHALL wrap the index only via the DONE path; no vector is repeated or skipped.

Reset
REQ-026 On rst_n low, SHALL immediately, including mid-scan:
- set state=IDLE;
- drive a, b, c, d, busy, done, match = 0;
- clear table_out, mismatch_count, first_fail, index and settle counter to 0.
REQ-027 After rst_n rises, SHALL accept no start before the first rising edge.

Structure
REQ-028 SHALL place in a shared package:
- the state enum;
- VEC_COUNT=16;
- IDX_W=4;
- CNT_W=5.
REQ-029 SHALL place the settle counter (load, count to SETTLE_CYCLES-1, terminal flag) in one sub-module named tt_settle_counter; all other logic stays in truth_table_scanner.

Verification
REQ-030 The bench model SHALL compute s = a ? (b ? d : c) : (b ^ c). Directed scenarios:
- Scan 1: start with expected=16'hAC3C, SETTLE_CYCLES=1 -> done at edge 32 after start, table_out=16'hAC3C, match=1, mismatch_count=0, first_fail=0.
- Scan 2: same model, expected=16'hAC3D -> table_out=16'hAC3C, match=0, mismatch_count=1, first_fail=0.
- Scan 3: model s stuck at 0, expected=16'hFFFF -> mismatch_count=16, first_fail=0, match=0.
- Scan 4: start pulsed again during busy and in the DONE cycle -> ignored, single done pulse, results unchanged.
- Scan 5: rst_n low at vector 7 mid-scan -> all outputs 0 immediately, state IDLE; a fresh start then completes correctly.
- Scan 6: SETTLE_CYCLES=3, model s delayed 2 cycles -> done at edge 64, table_out=16'hAC3C, match=1.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared types and sizing constants for the truth-table scanner.
package truth_table_scanner_pkg;

  localparam int VEC_COUNT = 16;  // vectors per scan (4 inputs)
  localparam int IDX_W     = 4;   // vector index width
  localparam int CNT_W     = 5;   // mismatch counter width (holds 0..16)
  localparam int SETTLE_W  = 4;   // settle counter width (SETTLE_CYCLES <= 15)

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tt_settle_counter.sv
// Settle counter: holds each vector for SETTLE_CYCLES cycles before sampling.
module tt_settle_counter
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,      // restart the count at zero
  input  logic en_i,        // count while the vector is settling
  output logic terminal_o   // last settle cycle of the current vector
);

  localparam logic [SETTLE_W-1:0] LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [SETTLE_W-1:0] cnt_q, cnt_d;

  assign terminal_o = (cnt_q == LAST);

  // Next count: load wins, otherwise advance until the terminal value.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !terminal_o) begin
      cnt_d = cnt_q + SETTLE_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Drives all 16 input vectors of a 4-input function, captures its response
// and compares the captured truth table against a golden table.
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [VEC_COUNT-1:0] expected,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  input  logic                 s,
  output logic                 busy,
  output logic                 done,
  output logic [VEC_COUNT-1:0] table_out,
  output logic                 match,
  output logic [CNT_W-1:0]     mismatch_count,
  output logic [IDX_W-1:0]     first_fail
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [VEC_COUNT-1:0] exp_q, exp_d;
  logic [VEC_COUNT-1:0] tbl_q, tbl_d;
  logic [CNT_W-1:0]     mm_q, mm_d;
  logic [IDX_W-1:0]     ff_q, ff_d;
  logic                 match_q, match_d;

  logic accept;
  logic settle_done;
  logic miss;

  assign accept = (state_q == ST_IDLE) && start;
  assign miss   = (s != exp_q[idx_q]);

  tt_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (accept || (state_q == ST_SAMPLE)),
    .en_i       (state_q == ST_DRIVE),
    .terminal_o (settle_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  if (settle_done) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs: the vector is visible only while a scan is active.
  always_comb begin
    busy         = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    done         = (state_q == ST_DONE);
    {a, b, c, d} = busy ? idx_q : '0;
  end

  // Result datapath: clear on accept, accumulate on every sample edge.
  always_comb begin
    idx_d   = idx_q;
    exp_d   = exp_q;
    tbl_d   = tbl_q;
    mm_d    = mm_q;
    ff_d    = ff_q;
    match_d = match_q;
    if (accept) begin
      idx_d   = '0;
      exp_d   = expected;
      tbl_d   = '0;
      mm_d    = '0;
      ff_d    = '0;
      match_d = 1'b0;
    end else if (state_q == ST_SAMPLE) begin
      tbl_d[idx_q] = s;
      if (miss) begin
        mm_d = mm_q + CNT_W'(1);
        // Only the first mismatch of the scan records its index.
        if (mm_q == '0) ff_d = idx_q;
      end
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        match_d = (mm_d == '0);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Result and index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      exp_q   <= '0;
      tbl_q   <= '0;
      mm_q    <= '0;
      ff_q    <= '0;
      match_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      exp_q   <= exp_d;
      tbl_q   <= tbl_d;
      mm_q    <= mm_d;
      ff_q    <= ff_d;
      match_q <= match_d;
    end
  end

  assign table_out      = tbl_q;
  assign mismatch_count = mm_q;
  assign first_fail     = ff_q;
  assign match          = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE_CYCLES 1 and 3), each
// fed by a configurable behavioural function under test.
module tb_truth_table_scanner;

  logic clk = 1'b0;
  logic rst_n;

  logic [1:0]       start_v;
  logic [1:0][15:0] exp_v;
  logic [1:0]       a_v, b_v, c_v, d_v, s_v, busy_v, done_v, match_v;
  logic [1:0][15:0] tbl_v;
  logic [1:0][4:0]  mm_v;
  logic [1:0][3:0]  ff_v;
  logic [1:0][3:0]  vec_v;
  logic [1:0][3:0]  dly1, dly2;

  // Function-under-test mode per instance: 0 comb model, 1 stuck-at-0,
  // 2 model delayed two cycles, 3 random lookup table.
  int               mode_v [2];
  logic [1:0][15:0] fn_v;

  int checks = 0;
  int errors = 0;

  logic [15:0] r_tbl;
  logic [4:0]  r_mm;
  logic [3:0]  r_ff;
  logic        r_match;

  always #5 clk = ~clk;

  truth_table_scanner #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .expected(exp_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .d(d_v[0]), .s(s_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .table_out(tbl_v[0]), .match(match_v[0]),
    .mismatch_count(mm_v[0]), .first_fail(ff_v[0])
  );

  truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .expected(exp_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .d(d_v[1]), .s(s_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .table_out(tbl_v[1]), .match(match_v[1]),
    .mismatch_count(mm_v[1]), .first_fail(ff_v[1])
  );

  function automatic logic model_f(input logic [3:0] v);
    logic fa, fb, fc, fd;
    {fa, fb, fc, fd} = v;
    return fa ? (fb ? fd : fc) : (fb ^ fc);
  endfunction

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      vec_v[k] = {a_v[k], b_v[k], c_v[k], d_v[k]};
      case (mode_v[k])
        0:       s_v[k] = model_f(vec_v[k]);
        1:       s_v[k] = 1'b0;
        2:       s_v[k] = model_f(dly2[k]);
        default: s_v[k] = fn_v[k][vec_v[k]];
      endcase
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      dly1[k] <= vec_v[k];
      dly2[k] <= dly1[k];
    end
  end

  // Truth table the instance should capture, from the function definition.
  function automatic logic [15:0] ref_table(input int sel);
    logic [15:0] t;
    for (int i = 0; i < 16; i++) begin
      case (mode_v[sel])
        0, 2:    t[i] = model_f(4'(i));
        1:       t[i] = 1'b0;
        default: t[i] = fn_v[sel][i];
      endcase
    end
    return t;
  endfunction

  // Runs one scan; noisy pulses start while busy and in the DONE cycle and
  // scrambles expected after acceptance.
  task automatic run_scan(input int sel, input logic [15:0] exp, input bit noisy);
    int  settle, n_exp, n, bad_vec, bad_busy, lat;
    bit  seen;
    settle = (sel == 0) ? 1 : 3;
    n_exp  = 16 * (settle + 1);
    @(negedge clk);
    start_v[sel] = 1'b1;
    exp_v[sel]   = exp;
    @(posedge clk);
    n = 0; bad_vec = 0; bad_busy = 0; seen = 1'b0; lat = -1;
    while (!seen && n <= n_exp + 8) begin
      @(negedge clk);
      if (done_v[sel]) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        if (busy_v[sel] !== 1'b1) bad_busy++;
        if (vec_v[sel] !== 4'(n / (settle + 1))) bad_vec++;
        start_v[sel] = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) exp_v[sel] = 16'($urandom);
        @(posedge clk);
        n++;
      end
    end
    checks++;
    if (lat != n_exp) begin
      errors++;
      $display("FAIL latency[%0d]: done after %0d edges, want %0d", sel, lat, n_exp);
    end
    checks++;
    if (bad_vec != 0 || bad_busy != 0) begin
      errors++;
      $display("FAIL vector_sequence[%0d]: %0d bad vectors, %0d busy drops, want 0", sel, bad_vec, bad_busy);
    end
    if (seen) begin
      r_tbl = tbl_v[sel]; r_mm = mm_v[sel]; r_ff = ff_v[sel]; r_match = match_v[sel];
      start_v[sel] = noisy;
      @(negedge clk);
      start_v[sel] = 1'b0;
      checks++;
      if (done_v[sel] !== 1'b0 || busy_v[sel] !== 1'b0) begin
        errors++;
        $display("FAIL done_pulse[%0d]: done=%b busy=%b, want 0 0", sel, done_v[sel], busy_v[sel]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (busy_v[sel] !== 1'b0) begin
        errors++;
        $display("FAIL no_restart[%0d]: busy=%b, want 0", sel, busy_v[sel]);
      end
    end else begin
      start_v[sel] = 1'b0;
      r_tbl = 'x; r_mm = 'x; r_ff = 'x; r_match = 1'bx;
    end
  endtask

  // Compares the results captured at done, and those still held in IDLE,
  // against the reference model.
  task automatic compare_with_model(input string name, input int sel, input logic [15:0] exp);
    logic [15:0] want_tbl, diff;
    logic [3:0]  want_ff;
    int          want_mm;
    want_tbl = ref_table(sel);
    diff     = want_tbl ^ exp;
    want_mm  = $countones(diff);
    want_ff  = '0;
    for (int i = 15; i >= 0; i--) if (diff[i]) want_ff = 4'(i);
    checks++;
    if (r_tbl !== want_tbl) begin
      errors++; $display("FAIL %s table_out: got %h want %h", name, r_tbl, want_tbl);
    end
    checks++;
    if (r_mm !== 5'(want_mm)) begin
      errors++; $display("FAIL %s mismatch_count: got %0d want %0d", name, r_mm, want_mm);
    end
    checks++;
    if (r_ff !== want_ff) begin
      errors++; $display("FAIL %s first_fail: got %0d want %0d", name, r_ff, want_ff);
    end
    checks++;
    if (r_match !== (diff == '0)) begin
      errors++; $display("FAIL %s match: got %b want %b", name, r_match, diff == '0);
    end
    checks++;
    if (tbl_v[sel] !== want_tbl || mm_v[sel] !== 5'(want_mm) || match_v[sel] !== (diff == '0)) begin
      errors++;
      $display("FAIL %s held_in_idle: table %h mm %0d match %b, want %h %0d %b",
               name, tbl_v[sel], mm_v[sel], match_v[sel], want_tbl, want_mm, diff == '0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_v = '0; exp_v = '0;
    mode_v[0] = 0; mode_v[1] = 0; fn_v = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({vec_v[k], busy_v[k], done_v[k], match_v[k], tbl_v[k], mm_v[k], ff_v[k]} !== '0) begin
        errors++;
        $display("FAIL reset_state[%0d]: vec %h busy %b done %b match %b table %h mm %0d ff %0d, want all 0",
                 k, vec_v[k], busy_v[k], done_v[k], match_v[k], tbl_v[k], mm_v[k], ff_v[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scan_match();
    mode_v[0] = 0;
    run_scan(0, 16'hAC3C, 1'b0);
    compare_with_model("scan1_match", 0, 16'hAC3C);
  endtask

  task automatic test_scan_single_miss();
    mode_v[0] = 0;
    run_scan(0, 16'hAC3D, 1'b0);
    compare_with_model("scan2_one_miss", 0, 16'hAC3D);
  endtask

  task automatic test_scan_all_miss();
    mode_v[0] = 1;
    run_scan(0, 16'hFFFF, 1'b0);
    compare_with_model("scan3_all_miss", 0, 16'hFFFF);
  endtask

  task automatic test_start_ignored();
    mode_v[0] = 0;
    run_scan(0, 16'h2C3C, 1'b1);
    compare_with_model("scan4_start_ignored", 0, 16'h2C3C);
  endtask

  task automatic test_reset_mid_scan();
    int guard;
    mode_v[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1; exp_v[0] = 16'h0000;
    @(negedge clk);
    start_v[0] = 1'b0;
    guard = 0;
    while (vec_v[0] !== 4'd7 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (vec_v[0] !== 4'd7) begin
      errors++; $display("FAIL reach_vector7: vector %0d, want 7", vec_v[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({vec_v[0], busy_v[0], done_v[0], match_v[0], tbl_v[0], mm_v[0], ff_v[0]} !== '0) begin
      errors++;
      $display("FAIL mid_scan_reset: vec %h busy %b done %b match %b table %h mm %0d ff %0d, want all 0",
               vec_v[0], busy_v[0], done_v[0], match_v[0], tbl_v[0], mm_v[0], ff_v[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(0, 16'hAC3C, 1'b0);
    compare_with_model("scan5_after_reset", 0, 16'hAC3C);
  endtask

  task automatic test_slow_settle();
    mode_v[1] = 2;
    run_scan(1, 16'hAC3C, 1'b0);
    compare_with_model("scan6_settle3", 1, 16'hAC3C);
  endtask

  task automatic test_random();
    logic [15:0] exp;
    int          sel;
    for (int r = 0; r < 6; r++) begin
      sel          = r % 2;
      mode_v[sel]  = 3;
      fn_v[sel]    = 16'($urandom);
      exp          = (r % 3 == 0) ? fn_v[sel] : 16'($urandom);
      run_scan(sel, exp, r[0]);
      compare_with_model($sformatf("random%0d", r), sel, exp);
    end
  endtask

  initial begin
    test_reset();
    test_scan_match();
    test_scan_single_miss();
    test_scan_all_miss();
    test_start_ignored();
    test_reset_mid_scan();
    test_slow_settle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
